fakeram_1r1w_param: RTL
=======================

Name: fakeram_1r1w_param

Overview:
- Parametrised behavioural SRAM macro model for the swerv flow.
- Successor to the single-port fixed-size fakeram macros.
- Separate read and write ports, per-bit write mask, configurable read latency with a valid strobe.
- Post-reset hardware init sweep that zeroes the array before accesses are accepted; used in RTL sim in place of hard macros.

Parameters:
- BITS, 34: data word width.
- WORD_DEPTH, 256: number of words; need not be a power of two.
- ADDR_WIDTH, $clog2(WORD_DEPTH): address width.
- READ_LATENCY, 1: cycles from read request edge to rd_valid; legal 1..4; elaboration error otherwise.

Ports:
- clk  input  1  clock; all state on posedge.
- rst_l  input  1  asynchronous active-low reset.
- init_done  output  1  high once the array is zeroed and ports are accepted.
- rd_en  input  1  read request, sampled on posedge.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  BITS  read data.
- rd_valid  output  1  one-cycle strobe per accepted read.
- wr_en  input  1  write request, sampled on posedge.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  BITS  write data.
- wr_mask  input  BITS  per-bit write enable; 1 means write the bit.

Behaviour:
- Reset (rst_l low, async):
  - rd_data=0, rd_valid=0, init_done=0.
  - FSM=INIT, init pointer=0, read pipeline flushed.
  - Array contents are not touched by reset itself.
- FSM INIT:
  - Each cycle writes 0 to mem[ptr], then ptr++.
  - The cycle ptr==WORD_DEPTH-1 is written, FSM goes to READY; init_done rises on that edge.
  - Init takes exactly WORD_DEPTH cycles after reset release.
  - rd_en and wr_en are ignored in INIT; rd_valid stays 0.
- FSM READY:
  - Holds until reset; no other transitions.
  - Write: mem[wr_addr] <= (wr_data & wr_mask) | (mem[wr_addr] & ~wr_mask).
  - Read: array sampled at the rd_en edge; result shifts through a READ_LATENCY-deep pipeline.
  - rd_valid pulses and rd_data updates exactly READ_LATENCY edges after the request edge.
  - Back-to-back reads give one strobe per cycle, fully pipelined.
  - rd_data holds its last valid value when rd_valid=0.
- Same-address collision (rd and wr to the same address on the same edge): read returns pre-write data.
- Writes are visible to reads issued on the following edge or later.
- Out of range (addr >= WORD_DEPTH):
  - Write is dropped.
  - Read still produces rd_valid with rd_data=0.
- Reset mid-operation:
  - In-flight reads are discarded with no rd_valid.
  - FSM re-enters INIT and re-zeroes the full array.
- wr_mask=0 with wr_en=1: the array is unchanged.

Optional Feature:
- Macro: FAKERAM_X_CORRUPT_EN.
- Defined: in READY, if wr_en, rd_en, or the address of an enabled port is X or Z on an edge:
  - every word becomes X;
  - that read returns X with rd_valid=1;
  - $display warning with instance name, enables and addresses.
- Undefined: no X checks; X on an enable is treated as 0 and no warning is printed.

Decomposition:
- Package fakeram_pkg:
  - state enum {FR_INIT, FR_READY};
  - constants FR_MIN_LAT=1, FR_MAX_LAT=4.
- Sub-module fakeram_rd_pipe: parametrised valid/data delay line (BITS, READ_LATENCY), async active-low clear of valid bits and data.
- Top-level holds the array, FSM, init pointer and write logic.

Test Plan:
- Release reset with WORD_DEPTH=256 → init_done=0 for 255 edges and rises on edge 256; a read of addr 0x80 then returns 0 with rd_valid.
- READY, READ_LATENCY=3: write 0x3_FFFF_FFFF to addr 5, then read addr 5 → rd_valid high 3 edges after the read edge, rd_data=0x3_FFFF_FFFF.
- Masked write: addr 7 holds 0x0_0000_00FF; write wr_data=0x3_FFFF_FF00 with wr_mask=0x0_0000_FF00 → read returns 0x0_0000_FFFF.
- Collision: addr 9 holds 0x11; write 0x22 and read addr 9 on the same edge → read returns 0x11; a read on the next edge returns 0x22.
- Reset mid-operation: assert rst_l low with 2 reads in flight → no rd_valid; after release the init sweep reruns and a previously written addr reads back 0.
- WORD_DEPTH=200: write to addr 210, then read addr 210 → rd_valid=1, rd_data=0; with FAKERAM_X_CORRUPT_EN, wr_en=X → any read returns X and a warning is printed.

Source files
------------

// File: rtl/fakeram_pkg.sv
// fakeram_pkg: shared state encoding and read-latency limits for the fakeram macro models
package fakeram_pkg;
  typedef enum logic {FR_INIT, FR_READY} fr_state_e;
  localparam int FR_MIN_LAT = 1;
  localparam int FR_MAX_LAT = 4;
endpackage

// File: rtl/fakeram_rd_pipe.sv
// fakeram_rd_pipe: valid/data delay line; data only advances with its valid so the output holds
module fakeram_rd_pipe #(
  parameter int BITS = 34,
  parameter int READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            in_valid,
  input  logic [BITS-1:0] in_data,
  output logic            out_valid,
  output logic [BITS-1:0] out_data
);
  logic [READ_LATENCY-1:0] v;
  logic [BITS-1:0]         d [READ_LATENCY];
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      if (in_valid) d[0] <= in_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end
  assign out_valid = v[READ_LATENCY-1];
  assign out_data  = d[READ_LATENCY-1];
endmodule

// File: rtl/fakeram_1r1w_param.sv
// fakeram_1r1w_param: 1R1W behavioural SRAM with masked writes, post-reset zero sweep and delayed read strobe.
// Define FAKERAM_X_CORRUPT_EN to poison the array when an enable or an enabled address is X/Z.
module fakeram_1r1w_param
  import fakeram_pkg::*;
#(
  parameter int BITS = 34,
  parameter int WORD_DEPTH = 256,
  parameter int ADDR_WIDTH = $clog2(WORD_DEPTH),
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_l,
  output logic                  init_done,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [BITS-1:0]       rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BITS-1:0]       wr_data,
  input  logic [BITS-1:0]       wr_mask
);
  localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(WORD_DEPTH - 1);
  if (READ_LATENCY < FR_MIN_LAT || READ_LATENCY > FR_MAX_LAT) begin : g_lat_chk
    $error("fakeram_1r1w_param: READ_LATENCY %0d outside 1..4", READ_LATENCY);
  end
  fr_state_e             st, st_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [BITS-1:0]       mem [WORD_DEPTH];
  logic                  ready, rd_fire, wr_fire, s_valid, x_hit, x_rd;
  logic [BITS-1:0]       rd_word, s_in, s_data;
  assign ready     = st == FR_READY;
  assign init_done = ready;
  assign rd_fire   = ready && rd_en;
  assign wr_fire   = ready && wr_en && {1'b0, wr_addr} < DEPTH;
  assign rd_word   = {1'b0, rd_addr} < DEPTH ? mem[rd_addr] : '0;
`ifdef FAKERAM_X_CORRUPT_EN
  assign x_hit = ready && ($isunknown(wr_en) || $isunknown(rd_en) ||
                 (rd_en === 1'b1 && $isunknown(rd_addr)) || (wr_en === 1'b1 && $isunknown(wr_addr)));
  assign x_rd  = x_hit && rd_en !== 1'b0;
  assign s_in  = x_rd ? {BITS{1'bx}} : rd_word;
`else
  assign x_hit = 1'b0;
  assign x_rd  = 1'b0;
  assign s_in  = rd_word;
`endif
  always_comb st_nxt = (st == FR_INIT && ptr == LAST) ? FR_READY : st;
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      st      <= FR_INIT;
      ptr     <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
    end else begin
      st      <= st_nxt;
      if (!ready) ptr <= ptr + 1'b1;
      s_valid <= rd_fire || x_rd;
      if (rd_fire || x_rd) s_data <= s_in;
    end
  end
  // The array has no reset; the sweep only runs once rst_l is released.
  always_ff @(posedge clk) begin
`ifdef FAKERAM_X_CORRUPT_EN
    if (x_hit) begin
      for (int i = 0; i < WORD_DEPTH; i++) mem[i] <= {BITS{1'bx}};
      $display("%m: X/Z access, array corrupted: rd_en=%b rd_addr=%h wr_en=%b wr_addr=%h",
               rd_en, rd_addr, wr_en, wr_addr);
    end else
`endif
    if (!ready && rst_l) mem[ptr] <= '0;
    else if (wr_fire) mem[wr_addr] <= (wr_data & wr_mask) | (mem[wr_addr] & ~wr_mask);
  end
  fakeram_rd_pipe #(.BITS(BITS), .READ_LATENCY(READ_LATENCY)) u_rd_pipe (
    .clk       (clk),
    .rst_l     (rst_l),
    .in_valid  (s_valid),
    .in_data   (s_data),
    .out_valid (rd_valid),
    .out_data  (rd_data)
  );
endmodule
